// File: rtl/mult_block_reader_if.sv
// Block-read and output-stream signals between mult_block_reader and its neighbours.
// master: the reader itself; slave: multiplier plus downstream consumer.
interface mult_block_reader_if #(
  parameter int N = 32
);
  logic         EN_blockRead;
  logic         VALID_memVal;
  logic [N-1:0] memVal_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_last;

  modport master (
    output EN_blockRead,
    input  VALID_memVal,
    input  memVal_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  EN_blockRead,
    output VALID_memVal,
    output memVal_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/mult_block_reader.sv
// Requests product-memory blocks, buffers them in a fall-through FIFO and streams them out
// with a last-word tag, per-block checksum, block counter and sticky protocol-error flags.
module mult_block_reader #(
  parameter int N          = 32,
  parameter int BLOCK_LEN  = 64,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                              CLK,
  input  logic                              rst,
  input  logic                              drain_en,
  mult_block_reader_if.master               bus,
  output logic                              busy,
  output logic                              block_done,
  output logic [N+$clog2(BLOCK_LEN)-1:0]    block_sum,
  output logic [15:0]                       blocks_rcvd,
  output logic                              err_overflow,
  output logic                              err_unexpected
);

  localparam int SUM_W  = N + $clog2(BLOCK_LEN);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BLOCK_LEN) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  BLK_C     = CNT_W'(BLOCK_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t              state_q, state_d;
  logic                en_q, en_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [15:0]         blocks_q, blocks_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_unx_q, err_unx_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N:0]          mem_q [FIFO_DEPTH];

  logic                push, push_last, push_ok, pop, full, fifo_valid;
  logic [CNT_W-1:0]    free_entries;
  logic [N:0]          head;

  assign fifo_valid   = (cnt_q != '0);
  assign full         = (cnt_q == DEPTH_C);
  assign free_entries = DEPTH_C - cnt_q;
  assign pop          = fifo_valid && bus.out_ready;
  assign push_ok      = push && (!full || pop);
  assign head         = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    blocks_d  = blocks_q;
    err_ovf_d = err_ovf_q;
    err_unx_d = err_unx_q;
    push      = 1'b0;
    push_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.VALID_memVal) err_unx_d = 1'b1;
        if (drain_en && (free_entries >= BLK_C)) state_d = REQ;
      end
      REQ, RECV: begin
        // The first beat arrives with beat_q/acc_q already cleared, so REQ and RECV share the update.
        if (bus.VALID_memVal) begin
          push      = 1'b1;
          push_last = (beat_q == LAST_BEAT);
          beat_d    = beat_q + 1'b1;
          acc_d     = acc_q + SUM_W'(bus.memVal_data);
          state_d   = push_last ? DONE : RECV;
        end
      end
      DONE: begin
        if (bus.VALID_memVal) err_unx_d = 1'b1;
        sum_d    = acc_q;
        blocks_d = blocks_q + 16'd1;
        acc_d    = '0;
        beat_d   = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (push && full && !pop) err_ovf_d = 1'b1;
    en_d = (state_d == REQ);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      beat_q    <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      blocks_q  <= '0;
      err_ovf_q <= 1'b0;
      err_unx_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      beat_q    <= beat_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      blocks_q  <= blocks_d;
      err_ovf_q <= err_ovf_d;
      err_unx_q <= err_unx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage is data only; occupancy is tracked by the reset pointers and count.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_last, bus.memVal_data};
  end

  assign bus.EN_blockRead = en_q;
  assign bus.out_valid    = fifo_valid;
  assign bus.out_data     = fifo_valid ? head[N-1:0] : '0;
  assign bus.out_last     = fifo_valid & head[N];
  assign busy             = (state_q != IDLE);
  assign block_done       = (state_q == DONE);
  assign block_sum        = sum_q;
  assign blocks_rcvd      = blocks_q;
  assign err_overflow     = err_ovf_q;
  assign err_unexpected   = err_unx_q;

endmodule

// File: tb/tb_mult_block_reader.sv
// Randomized scoreboard bench for mult_block_reader: the driver queues expected words and
// block sums as it delivers beats; a negedge monitor pops and compares whatever the DUT emits.
module tb_mult_block_reader;
  localparam int N     = 32;
  localparam int BL    = 64;
  localparam int SUM_W = N + $clog2(BL);

  logic             CLK;
  logic             rst;
  logic             drain_en;
  logic             busy;
  logic             block_done;
  logic [SUM_W-1:0] block_sum;
  logic [15:0]      blocks_rcvd;
  logic             err_overflow;
  logic             err_unexpected;

  mult_block_reader_if #(.N(N)) bus ();

  mult_block_reader #(.N(N), .BLOCK_LEN(BL), .FIFO_DEPTH(64)) dut (
    .CLK            (CLK),
    .rst            (rst),
    .drain_en       (drain_en),
    .bus            (bus),
    .busy           (busy),
    .block_done     (block_done),
    .block_sum      (block_sum),
    .blocks_rcvd    (blocks_rcvd),
    .err_overflow   (err_overflow),
    .err_unexpected (err_unexpected)
  );

  int               checks = 0;
  int               errors = 0;
  logic [N:0]       exp_q[$];
  logic [SUM_W-1:0] sum_q[$];
  logic [15:0]      exp_blocks = 16'd0;
  bit               pend = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares every accepted output word and every completed-block report.
  initial begin
    logic [N:0]       e;
    logic [SUM_W-1:0] es;
    forever begin
      @(negedge CLK);
      if (rst) begin
        exp_q.delete();
        sum_q.delete();
        exp_blocks = 16'd0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          pend = 1'b0;
          if (sum_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL block_report: got block_done required none pending");
          end else begin
            es = sum_q.pop_front();
            exp_blocks = exp_blocks + 16'd1;
            check("block_sum", 64'(block_sum), 64'(es));
            check("blocks_rcvd", 64'(blocks_rcvd), 64'(exp_blocks));
          end
        end
        if (block_done) pend = 1'b1;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_word: got %0h required no output", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(bus.out_data), 64'(e[N-1:0]));
            check("out_last", 64'(bus.out_last), 64'(e[N]));
          end
        end
      end
    end
  end

  // pat: 0 = index, 1 = all ones, 2 = random. ready_beat: -1 leave out_ready,
  // -2 randomize it per beat, k>=0 raise it together with beat k.
  task automatic deliver_block(input int pat, input int gap_max, input int nbeats, input int ready_beat);
    logic [SUM_W-1:0] sum;
    logic [N-1:0]     w;
    int               t;
    int               g;
    bit               last;
    drain_en = 1'b1;
    t = 0;
    while (bus.EN_blockRead !== 1'b1 && t < 1000) begin
      tick();
      t++;
    end
    if (bus.EN_blockRead !== 1'b1) begin
      checks++; errors++;
      $display("FAIL en_blockread_wait: got %0b required 1", bus.EN_blockRead);
      drain_en = 1'b0;
      return;
    end
    sum = '0;
    for (int i = 0; i < nbeats; i++) begin
      if (ready_beat == -2) bus.out_ready = 1'($urandom);
      else if (ready_beat == i) bus.out_ready = 1'b1;
      case (pat)
        0:       w = N'(i);
        1:       w = '1;
        default: w = N'($urandom);
      endcase
      last = (i == BL - 1);
      sum = sum + SUM_W'(w);
      bus.VALID_memVal = 1'b1;
      bus.memVal_data  = w;
      exp_q.push_back({last, w});
      if (last) begin
        sum_q.push_back(sum);
        drain_en = 1'b0;
      end
      tick();
      bus.VALID_memVal = 1'b0;
      if (i == 0) check("en_drop_after_first", 64'(bus.EN_blockRead), 64'd0);
      if (gap_max > 0 && !last) begin
        g = $urandom_range(gap_max, 1);
        for (int k = 0; k < g; k++) begin
          tick();
          check("busy_in_gap", 64'(busy), 64'd1);
        end
      end
    end
    if (ready_beat == -2) bus.out_ready = 1'b1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || sum_q.size() != 0 || bus.out_valid || busy || pend) && t < 2000) begin
      tick();
      t++;
    end
    check("drain_timeout", 64'(t < 2000), 64'd1);
  endtask

  initial begin
    logic [SUM_W-1:0] bs;
    rst = 1'b1;
    drain_en = 1'b0;
    bus.VALID_memVal = 1'b0;
    bus.memVal_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_en", 64'(bus.EN_blockRead), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(block_sum), 64'd0);
    check("rst_blocks", 64'(blocks_rcvd), 64'd0);
    check("rst_errs", 64'({err_overflow, err_unexpected}), 64'd0);
    rst = 1'b0;
    tick();

    // Basic block of 0..63 with out_ready held high.
    deliver_block(0, 0, BL, -1);
    wait_drain();
    check("basic_sum_2016", 64'(block_sum), 64'd2016);

    // Gapped all-ones block.
    deliver_block(1, 3, BL, -1);
    wait_drain();
    check("gapped_sum", 64'(block_sum), 64'h3F_FFFF_FFC0);

    // Stray beat while idle.
    bs = block_sum;
    bus.VALID_memVal = 1'b1;
    bus.memVal_data = N'($urandom);
    tick();
    bus.VALID_memVal = 1'b0;
    tick();
    tick();
    check("stray_err_unexpected", 64'(err_unexpected), 64'd1);
    check("stray_fifo_empty", 64'(bus.out_valid), 64'd0);
    check("stray_sum_kept", 64'(block_sum), 64'(bs));
    check("stray_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    check("stray_sticky", 64'(err_unexpected), 64'd1);

    // Backpressure: a full FIFO must block the next request.
    bus.out_ready = 1'b0;
    deliver_block(2, 0, BL, -1);
    drain_en = 1'b1;
    repeat (10) tick();
    check("bp_no_request", 64'(bus.EN_blockRead), 64'd0);
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    deliver_block(2, 0, BL, -1);
    wait_drain();
    check("bp_no_overflow", 64'(err_overflow), 64'd0);

    // 63 entries buffered, then final beat coincides with the first pop.
    bus.out_ready = 1'b0;
    deliver_block(2, 0, BL, BL - 1);
    wait_drain();
    check("pushpop_no_overflow", 64'(err_overflow), 64'd0);

    // Random data, gaps and backpressure.
    for (int b = 0; b < 2; b++) begin
      deliver_block(2, 3, BL, -2);
      wait_drain();
    end

    // Reset after 20 beats of a block.
    bus.out_ready = 1'b1;
    deliver_block(2, 0, 20, -1);
    rst = 1'b1;
    drain_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_blocks", 64'(blocks_rcvd), 64'd0);
    check("midrst_err_unexpected", 64'(err_unexpected), 64'd0);
    deliver_block(0, 1, BL, -1);
    wait_drain();
    check("post_rst_sum", 64'(block_sum), 64'd2016);
    check("post_rst_blocks", 64'(blocks_rcvd), 64'd1);
    check("final_err_overflow", 64'(err_overflow), 64'd0);
    check("final_err_unexpected", 64'(err_unexpected), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_block_reader.md
Name: mult_block_reader

Overview:
- Consumer end of the multiplier's product-memory block-read interface.
- Requests a block with EN_blockRead and captures the BLOCK_LEN words delivered on VALID_memVal/memVal_data.
- Buffers the words in an internal FIFO and streams them downstream over a valid/ready handshake, tagging the last word of each block.
- Reports a per-block checksum, a block counter and sticky protocol-error flags.

Parameters:
N, 32, data word width (matches the product width)
BLOCK_LEN, 64, words per block read (product-memory depth)
FIFO_DEPTH, 64, internal buffer entries; must be >= BLOCK_LEN, power of two

Ports:
CLK  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
drain_en  input  1  level; permits requesting a new block
VALID_memVal  input  1  a block-read word is present this cycle
memVal_data  input  N  block-read word, sampled when VALID_memVal=1
EN_blockRead  output  1  block-read request to the multiplier
out_valid  output  1  out_data holds a buffered word
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  N  head-of-FIFO word
out_last  output  1  out_data is the final word of its block
busy  output  1  state != IDLE
block_done  output  1  one-cycle pulse after the final word of a block is captured
block_sum  output  N+$clog2(BLOCK_LEN)  sum of the last completed block
blocks_rcvd  output  16  completed-block count, wraps at 2^16
err_overflow  output  1  sticky; a word arrived with the FIFO full and no pop
err_unexpected  output  1  sticky; VALID_memVal seen in IDLE or DONE

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; FIFO is emptied.
  - Beat counter, accumulator, block_sum, blocks_rcvd and both error flags clear to 0.
  - All outputs are 0.
  - A reset mid-block discards buffered words and the partial sum.
- FSM states: IDLE, REQ, RECV, DONE.
- IDLE -> REQ when drain_en=1 and free entries (FIFO_DEPTH - count) >= BLOCK_LEN. A full block therefore always fits; the multiplier side has no backpressure.
- REQ:
  - EN_blockRead=1, registered, asserted the cycle after the transition and held until the first VALID_memVal.
  - On VALID_memVal: push the word, beat counter=1, accumulator=word, go to RECV. EN_blockRead=0 from the next cycle.
  - drain_en falling while in REQ does not abort the request.
- RECV:
  - Each VALID_memVal pushes the word, increments the beat counter and adds the word to the accumulator.
  - Gaps in VALID are allowed; the FSM waits with no timeout.
  - The beat that brings the counter to BLOCK_LEN is pushed with last=1; the FSM then goes to DONE.
- DONE, exactly one cycle:
  - block_done=1; block_sum <= accumulator; blocks_rcvd++.
  - Accumulator and beat counter clear; return to IDLE.
- Unexpected data: VALID_memVal in IDLE or DONE drops the word and sets err_unexpected. Neither the FIFO nor the sum changes.
- FIFO:
  - First-word fall-through, with a width of N+1 (data plus last tag).
  - out_valid = not empty; out_data/out_last come from the head entry.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are both accepted, and count is unchanged.
  - Push while full without a pop: the word is dropped, err_overflow is set, and beat counting still advances. This is unreachable with correct gating and is present for verification.
- Pointers wrap modulo FIFO_DEPTH.
- out_data is held stable while out_valid=1 and out_ready=0.
- Arithmetic:
  - The accumulator is unsigned, N+$clog2(BLOCK_LEN) bits wide, and cannot overflow.
  - blocks_rcvd wraps from 0xFFFF to 0.
- Latency: a word captured in cycle t is visible on out_data in cycle t+1 if the FIFO was empty.

Test Plan:
- Basic block: drain_en=1, out_ready=1; respond to EN_blockRead with 64 consecutive beats of data 0..63 → 64 outputs 0..63 in order, out_last only on 63, block_done pulse, block_sum=2016, blocks_rcvd=1.
- Backpressure: out_ready=0 throughout the first block → FIFO reaches 64. EN_blockRead stays 0 despite drain_en=1 until at least 64 entries are free. Then release out_ready → second block is requested; no err_overflow.
- Gapped delivery: 64 beats of 0xFFFFFFFF with random 1-3 cycle VALID gaps → block_sum=0x3F_FFFFFFC0, the last tag lands on the 64th word, and the FSM stays in RECV through the gaps.
- Stray beat: VALID_memVal=1 for one cycle while IDLE → err_unexpected=1 and stays set, FIFO count stays 0, block_sum unchanged.
- Reset mid-block: assert rst after 20 beats → out_valid=0, busy=0, blocks_rcvd=0, and a following full block yields the correct sum with no residue.
- Simultaneous push/pop: FIFO holds 63 entries with out_ready=1 while a beat arrives → count stays 63, no err_overflow, and output order is preserved.
